// File: rtl/i2c_txn_sequencer_pkg.sv
// Shared command codes, sequencer state/step encodings and the per-step command table
// for the register-level I2C transaction sequencer.
package i2c_txn_sequencer_pkg;

    localparam logic [2:0] k_cmd_start   = 3'd0;
    localparam logic [2:0] k_cmd_wr      = 3'd1;
    localparam logic [2:0] k_cmd_rd      = 3'd2;
    localparam logic [2:0] k_cmd_stop    = 3'd3;
    localparam logic [2:0] k_cmd_restart = 3'd4;

    localparam logic [2:0] st_idle  = 3'd0;
    localparam logic [2:0] st_issue = 3'd1;
    localparam logic [2:0] st_guard = 3'd2;
    localparam logic [2:0] st_wait  = 3'd3;
    localparam logic [2:0] st_resp  = 3'd4;

    typedef struct packed {
        logic       rw;
        logic [6:0] dev_addr;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } txn_req_t;

    // Write: START, dev, reg, data, STOP.  Read: START, dev, reg, RESTART, dev|1, RD, STOP.
    function automatic logic [2:0] step_cmd(input logic rw, input logic [2:0] step);
        logic [2:0] c;
        c = k_cmd_stop;
        if (rw) begin
            case (step)
                3'd0:    c = k_cmd_start;
                3'd1:    c = k_cmd_wr;
                3'd2:    c = k_cmd_wr;
                3'd3:    c = k_cmd_restart;
                3'd4:    c = k_cmd_wr;
                3'd5:    c = k_cmd_rd;
                default: c = k_cmd_stop;
            endcase
        end else begin
            case (step)
                3'd0:    c = k_cmd_start;
                3'd1:    c = k_cmd_wr;
                3'd2:    c = k_cmd_wr;
                3'd3:    c = k_cmd_wr;
                default: c = k_cmd_stop;
            endcase
        end
        return c;
    endfunction

    function automatic logic [7:0] step_din(input txn_req_t r, input logic [2:0] step);
        logic [7:0] d;
        d = 8'h00;
        case (step)
            3'd1:    d = {r.dev_addr, 1'b0};
            3'd2:    d = r.reg_addr;
            3'd3:    d = r.rw ? 8'h00 : r.wdata;
            3'd4:    d = r.rw ? {r.dev_addr, 1'b1} : 8'h00;
            3'd5:    d = r.rw ? 8'h01 : 8'h00;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] stop_step(input logic rw);
        return rw ? 3'd6 : 3'd4;
    endfunction

endpackage

// File: rtl/i2c_txn_sequencer.sv
// Turns one register read/write request into a START..STOP command sequence for the
// I2C byte engine, retrying the whole transaction on NACK.
module i2c_txn_sequencer
    import i2c_txn_sequencer_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic [2:0] cmd,
    output logic [7:0] din,
    output logic       wr_i2c,
    input  logic       ready,
    input  logic       done_tick,
    input  logic       ack,
    input  logic [7:0] dout
);

    localparam logic [3:0] max_retry_c = 4'(MAX_RETRY);

    logic [2:0] state_r, state_s;
    logic [2:0] step_r, step_s;
    logic [3:0] retry_r, retry_s;
    logic       nack_pend_r, nack_pend_s;
    txn_req_t   req_r, req_s;
    logic [2:0] cmd_r;
    logic [7:0] din_r;
    logic [7:0] rdata_r, rdata_s;
    logic       rsp_nack_r, rsp_nack_s;
    logic       cmd_done_s;

    // Next-state logic for the issue/guard/wait handshake and step sequencing.
    always_comb begin
        state_s     = state_r;
        step_s      = step_r;
        retry_s     = retry_r;
        nack_pend_s = nack_pend_r;
        req_s       = req_r;
        rdata_s     = rdata_r;
        rsp_nack_s  = rsp_nack_r;
        cmd_done_s  = ((cmd_r == k_cmd_wr) || (cmd_r == k_cmd_rd)) ? done_tick : ready;
        case (state_r)
            st_idle: begin
                if (req_valid) begin
                    req_s.rw       = req_rw;
                    req_s.dev_addr = req_dev_addr;
                    req_s.reg_addr = req_reg_addr;
                    req_s.wdata    = req_wdata;
                    step_s         = 3'd0;
                    retry_s        = 4'd0;
                    nack_pend_s    = 1'b0;
                    rdata_s        = 8'h00;
                    rsp_nack_s     = 1'b0;
                    state_s        = st_issue;
                end else begin
                    state_s = st_idle;
                end
            end
            st_issue: begin
                if (ready) begin
                    state_s = st_guard;
                end else begin
                    state_s = st_issue;
                end
            end
            st_guard: state_s = st_wait;
            st_wait: begin
                if (!cmd_done_s) begin
                    state_s = st_wait;
                end else if ((cmd_r == k_cmd_wr) && ack) begin
                    // A NACKed byte abandons the rest of the attempt; the bus still needs a STOP.
                    step_s      = stop_step(req_r.rw);
                    nack_pend_s = 1'b1;
                    state_s     = st_issue;
                end else if (cmd_r == k_cmd_stop) begin
                    if (!nack_pend_r) begin
                        state_s = st_resp;
                    end else if (retry_r < max_retry_c) begin
                        retry_s     = retry_r + 4'd1;
                        step_s      = 3'd0;
                        nack_pend_s = 1'b0;
                        state_s     = st_issue;
                    end else begin
                        rsp_nack_s = 1'b1;
                        rdata_s    = 8'h00;
                        state_s    = st_resp;
                    end
                end else begin
                    if (cmd_r == k_cmd_rd) begin
                        rdata_s = dout;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    step_s  = step_r + 3'd1;
                    state_s = st_issue;
                end
            end
            st_resp: begin
                if (rsp_ready) begin
                    retry_s = 4'd0;
                    state_s = st_idle;
                end else begin
                    state_s = st_resp;
                end
            end
            default: state_s = st_idle;
        endcase
    end

    // State, latched request and registered command/response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= st_idle;
            step_r      <= 3'd0;
            retry_r     <= 4'd0;
            nack_pend_r <= 1'b0;
            req_r       <= '0;
            cmd_r       <= k_cmd_start;
            din_r       <= 8'h00;
            rdata_r     <= 8'h00;
            rsp_nack_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            step_r      <= step_s;
            retry_r     <= retry_s;
            nack_pend_r <= nack_pend_s;
            req_r       <= req_s;
            cmd_r       <= step_cmd(req_s.rw, step_s);
            din_r       <= step_din(req_s, step_s);
            rdata_r     <= rdata_s;
            rsp_nack_r  <= rsp_nack_s;
        end
    end

    // The strobe must follow ready in the same cycle so the first command can go one cycle after acceptance.
    assign wr_i2c    = (state_r == st_issue) && ready;
    assign req_ready = (state_r == st_idle);
    assign rsp_valid = (state_r == st_resp);
    assign cmd       = cmd_r;
    assign din       = din_r;
    assign rsp_rdata = rdata_r;
    assign rsp_nack  = rsp_nack_r;

endmodule
